// File: rtl/synth_pkg.sv
// Shared types and defaults for the synth voice path.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        PRESENT = 2'd2
    } osc_state_t;

    // Also used by the codec interface, so keep them in one place.
    localparam int unsigned DEFAULT_SAMPLE_W = 24;
    localparam int unsigned DEFAULT_TICK_BIT = 9;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector on one bit of the clock-divider bus.
module tick_edge_detect #(
    parameter int unsigned BUS_W = 32,
    parameter int unsigned BIT   = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [BUS_W-1:0] bus,
    output logic             tick
);

    logic prev_q;

    // Only bus[BIT] matters; the rest of the bus is carried for a uniform hookup.
    logic unused_bits;
    assign unused_bits = ^bus;

    // History register; cleared so a bit already high after reset ticks once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= bus[BIT];
        end
    end

    assign tick = bus[BIT] & ~prev_q;

endmodule

// File: rtl/tone_osc.sv
// Phase-accumulator tone oscillator with a valid/ready sample output.
module tone_osc
    import synth_pkg::*;
#(
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int unsigned TICK_BIT = DEFAULT_TICK_BIT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                divided_clocks,
    input  logic [ACC_W-1:0]           tune_word,
    input  logic [1:0]                 wave_sel,
    input  logic                       gate,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic [7:0]                 overrun_count,
    output logic                       sample_tick
);

    logic                tick;
    logic [ACC_W-1:0]    acc_q;
    wave_t               wave_q;
    logic                gate_q;
    osc_state_t          state_q, state_d;
    logic [SAMPLE_W-1:0] wave_val;
    logic                xfer;

    tick_edge_detect #(
        .BUS_W (32),
        .BIT   (TICK_BIT)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .bus   (divided_clocks),
        .tick  (tick)
    );

    assign xfer = sample_valid & sample_ready;

    // Phase advance and per-tick capture of the voice controls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            wave_q      <= WAVE_SQUARE;
            gate_q      <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= tick;
            if (tick) begin
                acc_q  <= gate ? acc_q + tune_word : '0;
                wave_q <= wave_t'(wave_sel);
                gate_q <= gate;
            end
        end
    end

    // Waveform shaping from the accumulator top bits.
    always_comb begin
        logic [SAMPLE_W-1:0] p;
        logic [SAMPLE_W-2:0] t;
        p        = acc_q[ACC_W-1 -: SAMPLE_W];
        t        = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
        wave_val = '0;
        if (gate_q) begin
            unique case (wave_q)
                // Symmetric square: the most negative code is never produced.
                WAVE_SQUARE: wave_val = p[SAMPLE_W-1]
                    ? {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1}
                    : {1'b0, {(SAMPLE_W-1){1'b1}}};
                WAVE_SAW:    wave_val = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
                WAVE_TRI:    wave_val = {~t[SAMPLE_W-2], t[SAMPLE_W-3:0], 1'b0};
                WAVE_OFF:    wave_val = '0;
                default:     wave_val = '0;
            endcase
        end
    end

    // Next state: a tick always restarts the calculation, even mid-presentation.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            state_d = CALC;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                CALC:    state_d = PRESENT;
                PRESENT: if (xfer) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, output sample, handshake flag and overrun counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sample_out    <= '0;
            sample_valid  <= 1'b0;
            overrun_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CALC) begin
                sample_out   <= wave_val;
                sample_valid <= 1'b1;
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            // A pending sample that is not leaving this cycle will be overwritten.
            if (tick && sample_valid && !sample_ready && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tone_osc.sv
// Directed self-checking bench for tone_osc.
module tb_tone_osc;

    logic        clock;
    logic        reset;
    logic [31:0] divided_clocks;
    logic [31:0] tune_word;
    logic [1:0]  wave_sel;
    logic        gate;
    logic [23:0] sample_out;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  overrun_count;
    logic        sample_tick;

    int n_checks;
    int n_errors;

    tone_osc dut (
        .clock          (clock),
        .reset          (reset),
        .divided_clocks (divided_clocks),
        .tune_word      (tune_word),
        .wave_sel       (wave_sel),
        .gate           (gate),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .overrun_count  (overrun_count),
        .sample_tick    (sample_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One strobe on bit 9; returns in cycle T+2 where the new sample is visible.
    task automatic do_tick();
        divided_clocks[9] = 1'b1;
        step();
        divided_clocks[9] = 1'b0;
        step();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_out"}, {8'h0, sample_out}, 32'h0);
        check_eq({tag, "_valid"}, {31'h0, sample_valid}, 32'h0);
        check_eq({tag, "_ovr"}, {24'h0, overrun_count}, 32'h0);
        check_eq({tag, "_stick"}, {31'h0, sample_tick}, 32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        divided_clocks = '0;
        tune_word      = '0;
        wave_sel       = 2'd0;
        gate           = 1'b0;
        sample_ready   = 1'b0;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // Saw from acc = 0.
        wave_sel     = 2'd1;
        gate         = 1'b1;
        tune_word    = 32'h0100_0000;
        sample_ready = 1'b1;
        divided_clocks[9] = 1'b1;
        step();
        divided_clocks[9] = 1'b0;
        check_eq("saw_t1_stick", {31'h0, sample_tick}, 32'h1);
        check_eq("saw_t1_valid", {31'h0, sample_valid}, 32'h0);
        step();
        check_eq("saw_first", {8'h0, sample_out}, 32'h81_0000);
        check_eq("saw_first_valid", {31'h0, sample_valid}, 32'h1);
        step();
        check_eq("saw_valid_drop", {31'h0, sample_valid}, 32'h0);
        do_tick();
        check_eq("saw_second", {8'h0, sample_out}, 32'h82_0000);
        for (int i = 0; i < 254; i++) do_tick();
        check_eq("saw_wrap", {8'h0, sample_out}, 32'h80_0000);
        check_eq("saw_no_ovr", {24'h0, overrun_count}, 32'h0);

        // Square, half-scale step: acc alternates 0x8000_0000 / 0.
        wave_sel  = 2'd0;
        tune_word = 32'h8000_0000;
        do_tick();
        check_eq("sq_neg", {8'h0, sample_out}, 32'h80_0001);
        check_eq("sq_neg_valid", {31'h0, sample_valid}, 32'h1);
        step();
        check_eq("sq_neg_drop", {31'h0, sample_valid}, 32'h0);
        do_tick();
        check_eq("sq_pos", {8'h0, sample_out}, 32'h7F_FFFF);
        step();
        check_eq("sq_pos_drop", {31'h0, sample_valid}, 32'h0);
        do_tick();
        check_eq("sq_neg2", {8'h0, sample_out}, 32'h80_0001);

        // Gate off clears acc and silences; gate on restarts the saw.
        gate     = 1'b0;
        wave_sel = 2'd1;
        do_tick();
        check_eq("gate_off", {8'h0, sample_out}, 32'h0);
        check_eq("gate_off_valid", {31'h0, sample_valid}, 32'h1);
        gate      = 1'b1;
        tune_word = 32'h0100_0000;
        do_tick();
        check_eq("gate_on_saw", {8'h0, sample_out}, 32'h81_0000);

        // Triangle at acc = 0, 0x4000_0000, 0x8000_0000.
        gate = 1'b0;
        do_tick();
        gate      = 1'b1;
        wave_sel  = 2'd2;
        tune_word = 32'h0;
        do_tick();
        check_eq("tri_0", {8'h0, sample_out}, 32'h80_0000);
        tune_word = 32'h4000_0000;
        do_tick();
        check_eq("tri_q1", {8'h0, sample_out}, 32'h00_0000);
        do_tick();
        check_eq("tri_half", {8'h0, sample_out}, 32'h7F_FFFE);

        // Backpressure: three ticks with ready low, acc continues from 0x8000_0000.
        wave_sel  = 2'd1;
        tune_word = 32'h0100_0000;
        step();
        sample_ready = 1'b0;
        check_eq("bp_idle_valid", {31'h0, sample_valid}, 32'h0);
        for (int i = 0; i < 3; i++) do_tick();
        check_eq("bp_ovr", {24'h0, overrun_count}, 32'h2);
        check_eq("bp_out", {8'h0, sample_out}, 32'h03_0000);
        check_eq("bp_valid", {31'h0, sample_valid}, 32'h1);
        sample_ready = 1'b1;
        step();
        check_eq("bp_release", {31'h0, sample_valid}, 32'h0);
        sample_ready = 1'b0;

        // Tick coinciding with a transfer.
        do_tick();
        check_eq("co_pre_out", {8'h0, sample_out}, 32'h04_0000);
        sample_ready      = 1'b1;
        divided_clocks[9] = 1'b1;
        step();
        divided_clocks[9] = 1'b0;
        check_eq("co_valid_low", {31'h0, sample_valid}, 32'h0);
        check_eq("co_ovr", {24'h0, overrun_count}, 32'h2);
        step();
        check_eq("co_valid_back", {31'h0, sample_valid}, 32'h1);
        check_eq("co_out", {8'h0, sample_out}, 32'h05_0000);
        sample_ready = 1'b0;

        // Reset mid-stream with a pending sample and overrun = 3.
        do_tick();
        check_eq("mid_ovr", {24'h0, overrun_count}, 32'h3);
        check_eq("mid_valid", {31'h0, sample_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("post_reset_quiet", {31'h0, sample_valid}, 32'h0);
        sample_ready = 1'b1;
        divided_clocks[9] = 1'b1;
        step();
        divided_clocks[9] = 1'b0;
        check_eq("post_reset_t1", {31'h0, sample_valid}, 32'h0);
        step();
        check_eq("post_reset_out", {8'h0, sample_out}, 32'h81_0000);
        check_eq("post_reset_valid", {31'h0, sample_valid}, 32'h1);

        // Overrun saturation.
        step();
        sample_ready = 1'b0;
        for (int i = 0; i < 300; i++) do_tick();
        check_eq("sat_ovr", {24'h0, overrun_count}, 32'hFF);
        check_eq("sat_valid", {31'h0, sample_valid}, 32'h1);

        // Bit already high when reset releases ticks on the first cycle.
        reset             = 1'b1;
        divided_clocks[9] = 1'b1;
        step();
        reset = 1'b0;
        step();
        check_eq("rel_stick", {31'h0, sample_tick}, 32'h1);
        step();
        check_eq("rel_out", {8'h0, sample_out}, 32'h81_0000);
        check_eq("rel_valid", {31'h0, sample_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
